// File: rtl/count_seq_monitor_if.sv
// ----------------------------------------------------------------------------
// count_seq_monitor_if
//
// Bundles the monitored count stream and the monitor's status outputs.
//
//   master : the side that drives the count stream (counter / testbench)
//   slave  : the checker (count_seq_monitor)
//
// Signals:
//   CountIn   [WIDTH]  count value under test           (master -> slave)
//   SampleEn           sample CountIn on this edge       (master -> slave)
//   Locked             monitor is in LOCKED              (slave -> master)
//   ErrPulse           one-cycle sequence-error strobe   (slave -> master)
//   WrapPulse          one-cycle correct-wrap strobe     (slave -> master)
//   ErrCount  [ERR_W]  saturating error tally            (slave -> master)
//   Expected  [WIDTH]  next value the monitor expects    (slave -> master)
// ----------------------------------------------------------------------------
interface count_seq_monitor_if #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned ERR_W = 8
);

    logic [WIDTH-1:0] CountIn;
    logic             SampleEn;
    logic             Locked;
    logic             ErrPulse;
    logic             WrapPulse;
    logic [ERR_W-1:0] ErrCount;
    logic [WIDTH-1:0] Expected;

    modport master (
        output CountIn,
        output SampleEn,
        input  Locked,
        input  ErrPulse,
        input  WrapPulse,
        input  ErrCount,
        input  Expected
    );

    modport slave (
        input  CountIn,
        input  SampleEn,
        output Locked,
        output ErrPulse,
        output WrapPulse,
        output ErrCount,
        output Expected
    );

endinterface

// File: rtl/count_seq_monitor.sv
// ----------------------------------------------------------------------------
// count_seq_monitor
//
// Receive-side checker for a binary counter's count bus. Samples CountIn on
// edges where SampleEn=1 and checks that it advances by +1 modulo 2^WIDTH.
// After LOCK_RUN consecutive correct increments it enters LOCKED; from then on
// every sequence break raises ErrPulse for one cycle, bumps a saturating
// ErrCount and drops back to ACQUIRE. A correct max-to-0 step while LOCKED
// raises WrapPulse for one cycle. All outputs are registered and respond on the
// same edge that samples CountIn.
//
// Ports:
//   ClkIn  in   system clock, rising edge
//   Rst    in   asynchronous, active-high reset
//   mon    slave modport of count_seq_monitor_if (CountIn, SampleEn in;
//          Locked, ErrPulse, WrapPulse, ErrCount, Expected out)
//
// Parameters:
//   WIDTH     width of the monitored count bus
//   LOCK_RUN  consecutive correct increments needed to lock (1..15)
//   ERR_W     width of the error tally
//
// Build option:
//   COUNT_SEQ_MONITOR_HOLD_EN  when defined, CountIn == last is a legal pause:
//   in LOCKED it is ignored (no error, last unchanged), in ACQUIRE it leaves
//   the run length unchanged. When undefined, a repeated value is an ordinary
//   mismatch in every state.
// ----------------------------------------------------------------------------
module count_seq_monitor #(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned LOCK_RUN = 4,
    parameter int unsigned ERR_W    = 8
) (
    input logic                ClkIn,
    input logic                Rst,
    count_seq_monitor_if.slave mon
);

    // LOCK_RUN is at most 15, so a 4-bit run counter always suffices.
    localparam int unsigned RunW = 4;

    localparam logic [RunW-1:0]  LockRunVal = RunW'(LOCK_RUN);
    localparam logic [WIDTH-1:0] OneW       = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [ERR_W-1:0] OneE       = {{(ERR_W-1){1'b0}}, 1'b1};
    localparam logic [RunW-1:0]  OneR       = {{(RunW-1){1'b0}}, 1'b1};

    // Two bits give one spare encoding; it is caught by the default branch.
    typedef enum logic [1:0] {
        StIdle    = 2'b00,
        StAcquire = 2'b01,
        StLocked  = 2'b10
    } state_e;

    state_e           state_q;
    logic [RunW-1:0]  run_q;
    logic [WIDTH-1:0] last_q;
    logic             locked_q;
    logic             err_pulse_q;
    logic             wrap_pulse_q;
    logic [ERR_W-1:0] err_count_q;
    logic [WIDTH-1:0] expected_q;

    // ------------------------------------------------------------------------
    // Comparison helpers
    // ------------------------------------------------------------------------
    logic [WIDTH-1:0] last_inc;
    logic [WIDTH-1:0] count_inc;
    logic [RunW-1:0]  run_inc;
    logic [ERR_W-1:0] err_inc;
    logic             match;
    logic             count_zero;
    logic             err_sat;
    logic             run_done;

    always_comb begin
        last_inc   = last_q + OneW;      // truncates: all-ones + 1 = 0
        count_inc  = mon.CountIn + OneW;
        run_inc    = run_q + OneR;
        err_inc    = err_count_q + OneE;
        match      = (mon.CountIn == last_inc);
        count_zero = (mon.CountIn == '0);
        err_sat    = &err_count_q;
        run_done   = (run_inc == LockRunVal);
    end

`ifdef COUNT_SEQ_MONITOR_HOLD_EN
    logic hold;
    assign hold = (mon.CountIn == last_q);
`endif

    // ------------------------------------------------------------------------
    // FSM with registered outputs
    // ------------------------------------------------------------------------
    always_ff @(posedge ClkIn or posedge Rst) begin
        if (Rst) begin
            state_q      <= StIdle;
            run_q        <= '0;
            last_q       <= '0;
            locked_q     <= 1'b0;
            err_pulse_q  <= 1'b0;
            wrap_pulse_q <= 1'b0;
            err_count_q  <= '0;
            expected_q   <= '0;
        end else begin
            // Strobes default low; only a sampled event below raises them.
            err_pulse_q  <= 1'b0;
            wrap_pulse_q <= 1'b0;

            case (state_q)
                StIdle: begin
                    if (mon.SampleEn) begin
                        last_q     <= mon.CountIn;
                        run_q      <= '0;
                        expected_q <= count_inc;
                        locked_q   <= 1'b0;
                        state_q    <= StAcquire;
                    end
                end

                StAcquire: begin
                    if (mon.SampleEn) begin
                        if (match) begin
                            last_q     <= mon.CountIn;
                            run_q      <= run_inc;
                            expected_q <= count_inc;
                            if (run_done) begin
                                state_q  <= StLocked;
                                locked_q <= 1'b1;
                            end
`ifdef COUNT_SEQ_MONITOR_HOLD_EN
                        end else if (hold) begin
                            // Paused counter: keep run and last as they are.
                            run_q <= run_q;
`endif
                        end else begin
                            // Mismatches while acquiring just restart the run.
                            last_q     <= mon.CountIn;
                            run_q      <= '0;
                            expected_q <= count_inc;
                        end
                    end
                end

                StLocked: begin
                    if (mon.SampleEn) begin
                        if (match) begin
                            last_q       <= mon.CountIn;
                            expected_q   <= count_inc;
                            wrap_pulse_q <= count_zero;
`ifdef COUNT_SEQ_MONITOR_HOLD_EN
                        end else if (hold) begin
                            // Paused counter: stay locked, no error.
                            last_q <= last_q;
`endif
                        end else begin
                            err_pulse_q <= 1'b1;
                            if (!err_sat) begin
                                err_count_q <= err_inc;
                            end
                            last_q     <= mon.CountIn;
                            run_q      <= '0;
                            expected_q <= count_inc;
                            locked_q   <= 1'b0;
                            state_q    <= StAcquire;
                        end
                    end
                end

                default: begin
                    // Spare encoding: recover to IDLE regardless of SampleEn.
                    state_q    <= StIdle;
                    run_q      <= '0;
                    last_q     <= '0;
                    locked_q   <= 1'b0;
                    expected_q <= '0;
                end
            endcase
        end
    end

    assign mon.Locked    = locked_q;
    assign mon.ErrPulse  = err_pulse_q;
    assign mon.WrapPulse = wrap_pulse_q;
    assign mon.ErrCount  = err_count_q;
    assign mon.Expected  = expected_q;

endmodule

// File: tb/tb_count_seq_monitor.sv
// ----------------------------------------------------------------------------
// tb_count_seq_monitor
//
// Directed bench for count_seq_monitor. dut (ERR_W=8) covers reset, lock,
// wrap, break/relock, repeated value, SampleEn gating and asynchronous reset;
// dut_sat (ERR_W=2) covers tally saturation.
// ----------------------------------------------------------------------------
`timescale 1ns / 1ps

module tb_count_seq_monitor;

    logic ClkIn;
    logic Rst;

    int n_cmp = 0;
    int n_bad = 0;

    count_seq_monitor_if #(.WIDTH(4), .ERR_W(8)) bus ();
    count_seq_monitor_if #(.WIDTH(4), .ERR_W(2)) bus_sat ();

    count_seq_monitor #(
        .WIDTH    (4),
        .LOCK_RUN (4),
        .ERR_W    (8)
    ) dut (
        .ClkIn (ClkIn),
        .Rst   (Rst),
        .mon   (bus.slave)
    );

    count_seq_monitor #(
        .WIDTH    (4),
        .LOCK_RUN (4),
        .ERR_W    (2)
    ) dut_sat (
        .ClkIn (ClkIn),
        .Rst   (Rst),
        .mon   (bus_sat.slave)
    );

    initial ClkIn = 1'b0;
    always #50 ClkIn = ~ClkIn;

    task automatic check_value(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
        end
    endtask

    // Drive on the falling edge, sample 1 ns after the rising edge.
    task automatic step(input logic [3:0] c, input logic en);
        @(negedge ClkIn);
        bus.CountIn  = c;
        bus.SampleEn = en;
        @(posedge ClkIn);
        #1;
    endtask

    task automatic step_sat(input logic [3:0] c, input logic en);
        @(negedge ClkIn);
        bus_sat.CountIn  = c;
        bus_sat.SampleEn = en;
        @(posedge ClkIn);
        #1;
    endtask

    task automatic check_all(input string tag, input logic lk, input logic ep,
                             input logic wp, input logic [7:0] ec,
                             input logic [3:0] ex);
        check_value({tag, ".locked"}, 32'(bus.Locked), 32'(lk));
        check_value({tag, ".err"},    32'(bus.ErrPulse), 32'(ep));
        check_value({tag, ".wrap"},   32'(bus.WrapPulse), 32'(wp));
        check_value({tag, ".errcnt"}, 32'(bus.ErrCount), 32'(ec));
        check_value({tag, ".expect"}, 32'(bus.Expected), 32'(ex));
    endtask

    initial begin
        #1000000;
        $display("FAIL timeout: got running, want finished");
        $fatal(1);
    end

    initial begin
        logic [7:0] exp_err;
        logic [3:0] r;
        logic [3:0] last;
        logic [3:0] brk;
        logic [1:0] sat_exp;

        bus.CountIn      = '0;
        bus.SampleEn     = 1'b0;
        bus_sat.CountIn  = '0;
        bus_sat.SampleEn = 1'b0;

        // Reset
        Rst = 1'b1;
        #100;
        Rst = 1'b0;
        #1;
        check_all("reset", 1'b0, 1'b0, 1'b0, 8'd0, 4'd0);

        // Lock on 0..4
        step(4'd0, 1'b1);
        check_all("first", 1'b0, 1'b0, 1'b0, 8'd0, 4'd1);
        for (int i = 1; i <= 3; i++) begin
            step(4'(i), 1'b1);
            check_value("acq.locked", 32'(bus.Locked), 32'd0);
        end
        step(4'd4, 1'b1);
        check_all("lock", 1'b1, 1'b0, 1'b0, 8'd0, 4'd5);

        // Wrap: 5..15 then 0
        for (int i = 5; i <= 15; i++) begin
            step(4'(i), 1'b1);
            check_value("prewrap.wrap", 32'(bus.WrapPulse), 32'd0);
            check_value("prewrap.err", 32'(bus.ErrPulse), 32'd0);
        end
        step(4'd0, 1'b1);
        check_all("wrap", 1'b1, 1'b0, 1'b1, 8'd0, 4'd1);
        step(4'd1, 1'b1);
        check_all("postwrap", 1'b1, 1'b0, 1'b0, 8'd0, 4'd2);

        // Break 6 -> 9, then relock on 10..13
        for (int i = 2; i <= 6; i++) step(4'(i), 1'b1);
        check_value("prebreak.locked", 32'(bus.Locked), 32'd1);
        step(4'd9, 1'b1);
        check_all("break", 1'b0, 1'b1, 1'b0, 8'd1, 4'd10);
        step(4'd10, 1'b1);
        check_all("relock1", 1'b0, 1'b0, 1'b0, 8'd1, 4'd11);
        step(4'd11, 1'b1);
        step(4'd12, 1'b1);
        check_value("relock3.locked", 32'(bus.Locked), 32'd0);
        step(4'd13, 1'b1);
        check_all("relock", 1'b1, 1'b0, 1'b0, 8'd1, 4'd14);

        // Repeated value 3,3 while locked
        step(4'd14, 1'b1);
        step(4'd15, 1'b1);
        step(4'd0, 1'b1);
        step(4'd1, 1'b1);
        step(4'd2, 1'b1);
        step(4'd3, 1'b1);
        check_value("prehold.locked", 32'(bus.Locked), 32'd1);
        step(4'd3, 1'b1);
`ifdef COUNT_SEQ_MONITOR_HOLD_EN
        check_all("hold", 1'b1, 1'b0, 1'b0, 8'd1, 4'd4);
        exp_err = 8'd1;
`else
        check_all("repeat", 1'b0, 1'b1, 1'b0, 8'd2, 4'd4);
        exp_err = 8'd2;
`endif
        for (int i = 4; i <= 7; i++) step(4'(i), 1'b1);
        check_all("relock2", 1'b1, 1'b0, 1'b0, exp_err, 4'd8);

        // SampleEn=0 with arbitrary CountIn changes nothing
        for (int i = 0; i < 5; i++) begin
            r = 4'($urandom_range(15));
            step(r, 1'b0);
            check_all("gated", 1'b1, 1'b0, 1'b0, exp_err, 4'd8);
        end
        step(4'd8, 1'b1);
        check_all("ungated", 1'b1, 1'b0, 1'b0, exp_err, 4'd9);

        // Asynchronous reset mid-lock, between clock edges
        #20;
        Rst = 1'b1;
        #1;
        check_all("asyncrst", 1'b0, 1'b0, 1'b0, 8'd0, 4'd0);
        @(negedge ClkIn);
        Rst = 1'b0;
        step(4'd5, 1'b1);
        check_all("fresh", 1'b0, 1'b0, 1'b0, 8'd0, 4'd6);
        step(4'd9, 1'b1);
        check_all("acqmiss", 1'b0, 1'b0, 1'b0, 8'd0, 4'd10);
        step(4'd0, 1'b0);

        // Saturation with ERR_W=2: five errors, tally stops at 3
        for (int i = 0; i <= 4; i++) step_sat(4'(i), 1'b1);
        check_value("sat.lock", 32'(bus_sat.Locked), 32'd1);
        last = 4'd4;
        for (int k = 1; k <= 5; k++) begin
            brk = last + 4'd5;
            sat_exp = (k > 3) ? 2'd3 : 2'(k);
            step_sat(brk, 1'b1);
            check_value("sat.err", 32'(bus_sat.ErrPulse), 32'd1);
            check_value("sat.cnt", 32'(bus_sat.ErrCount), 32'(sat_exp));
            check_value("sat.locked", 32'(bus_sat.Locked), 32'd0);
            step_sat(4'd0, 1'b0);
            check_value("sat.gatedpulse", 32'(bus_sat.ErrPulse), 32'd0);
            for (int j = 1; j <= 4; j++) step_sat(brk + 4'(j), 1'b1);
            last = brk + 4'd4;
            check_value("sat.relock", 32'(bus_sat.Locked), 32'd1);
        end
        check_value("sat.final", 32'(bus_sat.ErrCount), 32'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
